fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 22 ++
 rtl/fetch_fifo.sv | 59 +++++
 rtl/fetch_unit.sv | 121 ++++++++++++
 tb/tb_fetch_unit.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared defaults, FSM encoding and buffer entry layout for the fetch unit
package fetch_pkg;

  localparam int          DEFAULT_DEPTH    = 4;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0;

  localparam int PC_W    = 32;
  localparam int INST_W  = 32;
  localparam int ENTRY_W = PC_W + INST_W;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

  typedef struct packed {
    logic [PC_W-1:0]   pc;
    logic [INST_W-1:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous prefetch FIFO with flush and simultaneous push/pop
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                       clock_in,
  input  logic                       clr,
  input  logic                       flush,
  input  logic                       push,
  input  logic [ENTRY_W-1:0]         push_data,
  input  logic                       pop,
  output logic [ENTRY_W-1:0]         head_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr;
  logic [PTR_W-1:0]   rd_ptr;
  logic               do_push;
  logic               do_pop;

  assign empty     = (count == '0);
  assign full      = (count == CNT_W'(DEPTH));
  assign do_pop    = pop && !empty;
  assign do_push   = push && (!full || do_pop);
  assign head_data = mem[rd_ptr];

  // Storage is cleared on reset so the head reads as zero until the first write.
  always_ff @(posedge clock_in) begin
    if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction prefetch: request FSM, fetch_pc and prefetch buffer
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int          DEPTH    = DEFAULT_DEPTH,
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clock_in,
  input  logic        clr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t       state;
  logic [31:0]        fetch_pc;
  logic               ack_hit;
  logic               pop;
  logic               push;
  logic               fifo_full;
  logic               fifo_empty;
  logic               slot_after_ack;
  logic [CNT_W-1:0]   count;
  logic [CNT_W-1:0]   occ_after;
  fetch_entry_t       push_entry;
  fetch_entry_t       head_entry;

  assign ack_hit    = imem_req && imem_ack;
  assign pop        = inst_valid && inst_ready;
  assign push       = (state == ST_WAIT) && ack_hit && !redirect;
  assign push_entry = '{pc: fetch_pc, inst: imem_rdata};

  // Occupancy after this cycle's pop and push decides whether to keep requesting.
  assign occ_after      = count - CNT_W'(pop) + CNT_W'(push);
  assign slot_after_ack = (occ_after <= CNT_W'(DEPTH - 1));

  assign inst_valid = !fifo_empty;
  assign inst       = head_entry.inst;
  assign inst_pc    = head_entry.pc;

  fetch_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock_in  (clock_in),
    .clr       (clr),
    .flush     (redirect),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head_data (head_entry),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_ff @(posedge clock_in) begin
    if (clr) begin
      state     <= ST_IDLE;
      fetch_pc  <= RESET_PC;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (redirect) begin
            fetch_pc  <= redirect_pc;
            imem_req  <= 1'b1;
            imem_addr <= redirect_pc;
            state     <= ST_WAIT;
          end else if (!fifo_full || pop) begin
            imem_req  <= 1'b1;
            imem_addr <= fetch_pc;
            state     <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (redirect) begin
            fetch_pc <= redirect_pc;
            if (ack_hit) begin
              imem_addr <= redirect_pc;
            end else begin
              state <= ST_DROP;
            end
          end else if (ack_hit) begin
            fetch_pc <= fetch_pc + 32'd1;
            if (slot_after_ack) begin
              imem_addr <= fetch_pc + 32'd1;
            end else begin
              imem_req <= 1'b0;
              state    <= ST_IDLE;
            end
          end
        end
        ST_DROP: begin
          // The buffer was flushed on entry and nothing is written here, so a slot is free.
          if (redirect) begin
            fetch_pc <= redirect_pc;
          end
          if (ack_hit) begin
            imem_addr <= redirect ? redirect_pc : fetch_pc;
            state     <= ST_WAIT;
          end
        end
        default: begin
          state    <= ST_IDLE;
          imem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - scoreboard bench for fetch_unit with a delayed-ack memory model
module tb_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = 32'h0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        inst_valid;
  logic        inst_ready = 1'b0;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  int total = 0;
  int bad   = 0;
  int pops  = 0;

  exp_t        exp_q[$];
  logic [31:0] acked_addrs[$];

  // Memory model knobs
  int   fix_delay  = 0;
  bit   rand_delay = 0;
  bit   force_ack  = 0;
  int   wait_cnt   = 0;
  int   cur_rand   = 0;
  bit   clr_edge   = 0;
  bit   req_pend   = 0;
  logic [31:0] pend_addr = 32'h0;

  // Monitor hold tracking
  bit          hold_pend = 0;
  logic [31:0] hold_pc   = 32'h0;
  logic [31:0] hold_inst = 32'h0;

  fetch_unit dut (
    .clock_in    (clk),
    .clr         (clr),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .inst_valid  (inst_valid),
    .inst_ready  (inst_ready),
    .inst        (inst),
    .inst_pc     (inst_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic load_seq(input logic [31:0] start);
    for (int i = 0; i < 16; i++) begin
      exp_q.push_back('{pc: start + 32'(i), inst: start + 32'(i) + 32'h100});
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Memory: acks after a configurable number of wait cycles, rdata = addr + 0x100.
  always begin
    @(posedge clk);
    clr_edge = clr;
    #2;
    if (req_pend && !clr_edge) begin
      chk("req_held", imem_req, 1'b1);
      chk("addr_stable", imem_addr, pend_addr);
    end
    if (force_ack) begin
      imem_ack   = 1'b1;
      imem_rdata = 32'hDEADBEEF;
    end else if (imem_req) begin
      if (wait_cnt >= (rand_delay ? cur_rand : fix_delay)) begin
        imem_ack   = 1'b1;
        imem_rdata = imem_addr + 32'h100;
        wait_cnt   = 0;
        cur_rand   = $urandom_range(0, 3);
      end else begin
        imem_ack = 1'b0;
        wait_cnt++;
      end
    end else begin
      imem_ack = 1'b0;
      wait_cnt = 0;
    end
    if (imem_req && imem_ack) acked_addrs.push_back(imem_addr);
    req_pend  = imem_req && !imem_ack;
    pend_addr = imem_addr;
  end

  // Scoreboard monitor: every head transfer pops one expected entry.
  always @(negedge clk) begin
    if (!clr) begin
      if (hold_pend) begin
        chk("hold_valid", inst_valid, 1'b1);
        chk("hold_pc", inst_pc, hold_pc);
        chk("hold_inst", inst, hold_inst);
      end
      if (inst_valid && inst_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL sb_underrun: got pc %h with no expected entry", inst_pc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("sb_pc", inst_pc, e.pc);
          chk("sb_inst", inst, e.inst);
          pops++;
          if (exp_q.size() < 8) load_seq(e.pc + 32'd1 + 32'(exp_q.size()));
        end
      end
    end
    hold_pend = !clr && inst_valid && !inst_ready && !redirect;
    hold_pc   = inst_pc;
    hold_inst = inst;
  end

  task automatic do_reset();
    clr      = 1'b1;
    redirect = 1'b0;
    cyc();
    @(negedge clk);
    chk("rst_req", imem_req, 1'b0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_valid", inst_valid, 1'b0);
    chk("rst_inst", inst, 32'h0);
    chk("rst_pc", inst_pc, 32'h0);
    cyc();
    exp_q.delete();
    acked_addrs.delete();
    load_seq(RESET_PC);
    clr = 1'b0;
  endtask

  task automatic do_redirect(input logic [31:0] tgt, output logic ack_pop, output int idx);
    redirect    = 1'b1;
    redirect_pc = tgt;
    @(negedge clk);
    ack_pop = imem_ack && inst_valid && inst_ready;
    idx     = acked_addrs.size();
    @(posedge clk);
    exp_q.delete();
    load_seq(tgt);
    #1 redirect = 1'b0;
    @(negedge clk);
    chk("flush_valid", inst_valid, 1'b0);
  endtask

  task automatic wait_acks(input int n, input string name);
    int k = 0;
    while (acked_addrs.size() < n && k < 40) begin
      @(negedge clk);
      k++;
    end
    chk(name, 32'(acked_addrs.size() >= n), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic ap;
    int   ix;
    int   p0;

    // Zero-wait stream straight out of reset
    inst_ready = 1'b1;
    fix_delay  = 0;
    do_reset();
    @(negedge clk);
    chk("c0_valid", inst_valid, 1'b0);
    @(negedge clk);
    chk("c1_valid", inst_valid, 1'b0);
    chk("c1_req", imem_req, 1'b1);
    chk("c1_addr", imem_addr, RESET_PC);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("burst_valid", inst_valid, 1'b1);
      chk("burst_pc", inst_pc, RESET_PC + 32'(k));
      chk("burst_inst", inst, RESET_PC + 32'(k) + 32'h100);
    end

    // Backpressure: exactly DEPTH requests, then drain and resume
    cyc();
    inst_ready = 1'b0;
    do_reset();
    repeat (10) cyc();
    @(negedge clk);
    chk("bp_acks", 32'(acked_addrs.size()), 32'd4);
    for (int k = 0; k < 4 && k < acked_addrs.size(); k++) chk("bp_addr", acked_addrs[k], 32'(k));
    chk("bp_req_low", imem_req, 1'b0);
    cyc();
    inst_ready = 1'b1;
    wait_acks(5, "bp_resume_timeout");
    if (acked_addrs.size() >= 5) chk("bp_resume_addr", acked_addrs[4], 32'd4);
    repeat (10) cyc();

    // Redirect while a slow request is outstanding
    fix_delay = 3;
    do_reset();
    cyc();
    cyc();
    do_redirect(32'h40, ap, ix);
    wait_acks(ix + 2, "drop_timeout");
    if (acked_addrs.size() >= ix + 2) begin
      chk("drop_old_addr", acked_addrs[ix], RESET_PC);
      chk("drop_new_addr", acked_addrs[ix+1], 32'h40);
    end
    repeat (20) cyc();

    // Two redirects while the dropped request is still pending
    fix_delay = 5;
    do_reset();
    cyc();
    cyc();
    do_redirect(32'h200, ap, ix);
    cyc();
    do_redirect(32'h300, ap, ix);
    wait_acks(ix + 2, "drop2_timeout");
    if (acked_addrs.size() >= ix + 2) chk("drop2_new_addr", acked_addrs[ix+1], 32'h300);
    repeat (30) cyc();

    // Redirect coinciding with ack and pop
    fix_delay = 0;
    do_reset();
    repeat (6) cyc();
    do_redirect(32'h80, ap, ix);
    chk("ackpop_cond", 32'(ap), 32'd1);
    wait_acks(ix + 1, "ackpop_timeout");
    if (acked_addrs.size() >= ix + 1) chk("ackpop_next_addr", acked_addrs[ix], 32'h80);
    repeat (10) cyc();

    // PC wrap
    do_redirect(32'hFFFFFFFE, ap, ix);
    p0 = pops;
    repeat (8) cyc();
    chk("wrap_progress", 32'(pops - p0 >= 4), 32'd1);

    // clr mid-WAIT with a late ack arriving during clr
    fix_delay = 3;
    do_reset();
    cyc();
    cyc();
    force_ack = 1'b1;
    do_reset();
    force_ack = 1'b0;
    wait_acks(1, "postclr_timeout");
    if (acked_addrs.size() >= 1) chk("postclr_addr", acked_addrs[0], RESET_PC);
    repeat (10) cyc();

    // Randomized traffic
    rand_delay = 1;
    do_reset();
    p0 = pops;
    for (int n = 0; n < 1500; n++) begin
      inst_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        do_redirect($urandom(), ap, ix);
      end
      cyc();
    end
    chk("rand_progress", 32'(pops - p0 > 200), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
